// File: rtl/bounce_sprites.sv
// bounce_sprites: multi-box bouncing screensaver renderer.
// NUM_BOXES boxes are updated one per clock after each frame_tick. Each box
// reflects off the screen edges and steps its colour (1..7) on every bounce.
// The pixel colour is composited with lowest-index priority and registered.
// Optional macro BOUNCE_SPRITES_OUTLINE_EN: draws the winning box's border
// pixels white.
//
// state  | meaning
// IDLE   | waiting for frame_tick
// UPDATE | updating box idx, one box per cycle
module bounce_sprites #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_BOXES     = 4,
  parameter int BOX_WIDTH     = 64,
  parameter int BOX_HEIGHT    = 48,
  parameter int VEL_W         = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_tick,
  input  logic                             visible,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  position_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] position_y,
  output logic [3:0]                       r,
  output logic [3:0]                       g,
  output logic [3:0]                       b,
  output logic                             busy,
  output logic                             done
);

  localparam int PXW   = $clog2(SCREEN_WIDTH);
  localparam int PYW   = $clog2(SCREEN_HEIGHT);
  localparam int XW    = PXW + 1;
  localparam int YW    = PYW + 1;
  localparam int IDX_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
  localparam logic signed [XW:0] X_LIM = (XW+1)'(SCREEN_WIDTH - BOX_WIDTH);
  localparam logic signed [YW:0] Y_LIM = (YW+1)'(SCREEN_HEIGHT - BOX_HEIGHT);
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(NUM_BOXES - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     done_q, done_d;
  logic [XW-1:0]            x_q [NUM_BOXES];
  logic [XW-1:0]            x_d [NUM_BOXES];
  logic [YW-1:0]            y_q [NUM_BOXES];
  logic [YW-1:0]            y_d [NUM_BOXES];
  logic signed [VEL_W-1:0]  vx_q [NUM_BOXES];
  logic signed [VEL_W-1:0]  vx_d [NUM_BOXES];
  logic signed [VEL_W-1:0]  vy_q [NUM_BOXES];
  logic signed [VEL_W-1:0]  vy_d [NUM_BOXES];
  logic [2:0]               color_q [NUM_BOXES];
  logic [2:0]               color_d [NUM_BOXES];
  logic [3:0]               r_q, r_d, g_q, g_d, b_q, b_d;

  logic signed [XW:0]       tx;
  logic signed [YW:0]       ty;
  logic                     hit_x, hit_y;

  logic [XW-1:0]            px_e;
  logic [YW-1:0]            py_e;
  logic                     found;
  logic [2:0]               win_color;
`ifdef BOUNCE_SPRITES_OUTLINE_EN
  logic                     on_edge;
`endif

  // State, box registers and registered pixel colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      r_q     <= 4'h0;
      g_q     <= 4'h0;
      b_q     <= 4'h0;
      for (int i = 0; i < NUM_BOXES; i++) begin
        x_q[i]     <= XW'(i * BOX_WIDTH);
        y_q[i]     <= YW'(i * (BOX_HEIGHT / 2));
        vx_q[i]    <= (i % 2 == 1) ? -VEL_W'(1 + i % 3) : VEL_W'(1 + i % 3);
        vy_q[i]    <= VEL_W'(1);
        color_q[i] <= 3'((i % 7) + 1);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      color_q <= color_d;
    end
  end

  // Sweep FSM: one box trajectory/colour update per UPDATE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    color_d = color_q;
    tx      = '0;
    ty      = '0;
    hit_x   = 1'b0;
    hit_y   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        tx = {1'b0, x_q[idx_q]} + {{(XW+1-VEL_W){vx_q[idx_q][VEL_W-1]}}, vx_q[idx_q]};
        ty = {1'b0, y_q[idx_q]} + {{(YW+1-VEL_W){vy_q[idx_q][VEL_W-1]}}, vy_q[idx_q]};
        if (tx[XW]) begin
          x_d[idx_q]  = '0;
          vx_d[idx_q] = -vx_q[idx_q];
          hit_x       = 1'b1;
        end else if (tx > X_LIM) begin
          x_d[idx_q]  = X_LIM[XW-1:0];
          vx_d[idx_q] = -vx_q[idx_q];
          hit_x       = 1'b1;
        end else begin
          x_d[idx_q]  = tx[XW-1:0];
        end
        if (ty[YW]) begin
          y_d[idx_q]  = '0;
          vy_d[idx_q] = -vy_q[idx_q];
          hit_y       = 1'b1;
        end else if (ty > Y_LIM) begin
          y_d[idx_q]  = Y_LIM[YW-1:0];
          vy_d[idx_q] = -vy_q[idx_q];
          hit_y       = 1'b1;
        end else begin
          y_d[idx_q]  = ty[YW-1:0];
        end
        if (hit_x || hit_y)
          color_d[idx_q] = (color_q[idx_q] == 3'd7) ? 3'd1 : color_q[idx_q] + 3'd1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel compositor: lowest-index box covering the pixel sets the colour.
  always_comb begin
    px_e      = {1'b0, position_x};
    py_e      = {1'b0, position_y};
    found     = 1'b0;
    win_color = 3'd0;
    r_d       = 4'h0;
    g_d       = 4'h0;
    b_d       = 4'h0;
`ifdef BOUNCE_SPRITES_OUTLINE_EN
    on_edge   = 1'b0;
`endif
    for (int i = 0; i < NUM_BOXES; i++) begin
      if (!found && px_e >= x_q[i] && px_e < x_q[i] + XW'(BOX_WIDTH) &&
          py_e >= y_q[i] && py_e < y_q[i] + YW'(BOX_HEIGHT)) begin
        found     = 1'b1;
        win_color = color_q[i];
`ifdef BOUNCE_SPRITES_OUTLINE_EN
        on_edge   = (px_e == x_q[i]) || (px_e == x_q[i] + XW'(BOX_WIDTH - 1)) ||
                    (py_e == y_q[i]) || (py_e == y_q[i] + YW'(BOX_HEIGHT - 1));
`endif
      end
    end
    if (visible && found) begin
      r_d = {4{win_color[0]}};
      g_d = {4{win_color[1]}};
      b_d = {4{win_color[2]}};
`ifdef BOUNCE_SPRITES_OUTLINE_EN
      if (on_edge) begin
        r_d = 4'hF;
        g_d = 4'hF;
        b_d = 4'hF;
      end
`endif
    end
  end

  assign r    = r_q;
  assign g    = g_q;
  assign b    = b_q;
  assign busy = (state_q == UPDATE);
  assign done = done_q;

endmodule

// File: tb/tb_bounce_sprites.sv
// Testbench for bounce_sprites: independent box model, pixel-probe scoreboard.
module tb_bounce_sprites;

  localparam int NB = 4;
  localparam int BW = 64;
  localparam int BH = 48;
  localparam int XL = 640 - 64;
  localparam int YL = 480 - 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       visible = 1'b0;
  logic [9:0] position_x = '0;
  logic [8:0] position_y = '0;
  logic [3:0] r, g, b;
  logic       busy, done;

  int checks = 0;
  int passes = 0;

  int mx [NB];
  int my [NB];
  int mvx [NB];
  int mvy [NB];
  int mc [NB];

  logic [11:0] exp_q [$];
  string       tag_q [$];

  bounce_sprites dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .visible    (visible),
    .position_x (position_x),
    .position_y (position_y),
    .r          (r),
    .g          (g),
    .b          (b),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [11:0] eo(input logic [11:0] c);
`ifdef BOUNCE_SPRITES_OUTLINE_EN
    return 12'hFFF;
`else
    return c;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      int v;
      v = 1 + i % 3;
      mx[i]  = i * BW;
      my[i]  = i * (BH / 2);
      mvx[i] = (i % 2 == 1) ? -v : v;
      mvy[i] = 1;
      mc[i]  = i % 7 + 1;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < NB; i++) begin
      int  t;
      bit  hit;
      hit = 0;
      t = mx[i] + mvx[i];
      if (t < 0)       begin mx[i] = 0;  mvx[i] = -mvx[i]; hit = 1; end
      else if (t > XL) begin mx[i] = XL; mvx[i] = -mvx[i]; hit = 1; end
      else mx[i] = t;
      t = my[i] + mvy[i];
      if (t < 0)       begin my[i] = 0;  mvy[i] = -mvy[i]; hit = 1; end
      else if (t > YL) begin my[i] = YL; mvy[i] = -mvy[i]; hit = 1; end
      else my[i] = t;
      if (hit) mc[i] = (mc[i] == 7) ? 1 : mc[i] + 1;
    end
  endtask

  function automatic logic [11:0] model_rgb(input int px, input int py, input bit vis);
    logic [2:0] c;
    if (!vis) return 12'h000;
    for (int i = 0; i < NB; i++) begin
      if (px >= mx[i] && px < mx[i] + BW && py >= my[i] && py < my[i] + BH) begin
        c = 3'(mc[i]);
`ifdef BOUNCE_SPRITES_OUTLINE_EN
        if (px == mx[i] || px == mx[i] + BW - 1 || py == my[i] || py == my[i] + BH - 1)
          return 12'hFFF;
`endif
        return {{4{c[0]}}, {4{c[1]}}, {4{c[2]}}};
      end
    end
    return 12'h000;
  endfunction

  task automatic probe(input string tag, input int px, input int py, input bit vis,
                       input logic [11:0] expv);
    logic [11:0] e;
    string       t;
    position_x = 10'(px);
    position_y = 9'(py);
    visible    = vis;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    visible = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {20'h0, r, g, b}, {20'h0, e});
  endtask

  task automatic probe_m(input string tag, input int px, input int py);
    if (px >= 0 && px < 640 && py >= 0 && py < 480)
      probe(tag, px, py, 1'b1, model_rgb(px, py, 1'b1));
  endtask

  task automatic probe_boxes(input string tag);
    for (int i = 0; i < NB; i++) begin
      probe_m($sformatf("%s_b%0d_tl", tag, i), mx[i], my[i]);
      probe_m($sformatf("%s_b%0d_left", tag, i), mx[i] - 1, my[i]);
      probe_m($sformatf("%s_b%0d_above", tag, i), mx[i], my[i] - 1);
      probe_m($sformatf("%s_b%0d_br", tag, i), mx[i] + BW - 1, my[i] + BH - 1);
      probe_m($sformatf("%s_b%0d_right", tag, i), mx[i] + BW, my[i] + BH - 1);
      probe_m($sformatf("%s_b%0d_below", tag, i), mx[i] + BW - 1, my[i] + BH);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    int n;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_within_budget", {31'h0, done}, 32'h1);
    model_tick();
  endtask

  task automatic tick_checked(input string tag);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("%s_busy_c%0d", tag, k), {31'h0, busy}, 32'h1);
      chk($sformatf("%s_nodone_c%0d", tag, k), {31'h0, done}, 32'h0);
      @(posedge clk); #1;
    end
    chk({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done_pulse"}, {31'h0, done}, 32'h1);
    @(posedge clk); #1;
    chk({tag, "_done_clear"}, {31'h0, done}, 32'h0);
    model_tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rgb", {20'h0, r, g, b}, 32'h0);
    probe("rst_box0_interior", 10, 10, 1'b1, 12'hF00);
    probe_boxes("rst");

    // One sweep: timing and positions
    tick_checked("t1");
    probe("t1_box0_corner", 1, 1, 1'b1, eo(12'hF00));
    probe("t1_left_of_box0", 0, 1, 1'b1, 12'h000);
    probe("t1_box0_over_box1", 63, 30, 1'b1, 12'hF00);
    probe("t1_invisible", 70, 30, 1'b0, 12'h000);
    probe("t1_box1_interior", 100, 40, 1'b1, 12'h0F0);
    probe("t1_right_of_box1", 126, 25, 1'b1, 12'h000);
    probe("t1_box2_corner", 131, 49, 1'b1, eo(12'hFF0));
    probe("t1_box2_interior", 150, 60, 1'b1, 12'hFF0);
    probe("t1_box3_interior", 200, 80, 1'b1, 12'h00F);
    probe_boxes("t1");

    // frame_tick during a sweep is ignored
    do_reset();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("dbl_done", {31'h0, done}, 32'h1);
    end
    model_tick();
    repeat (3) begin
      @(posedge clk); #1;
      chk("dbl_no_second_sweep", {31'h0, busy}, 32'h0);
    end
    probe("dbl_box0_x1", 1, 1, 1'b1, eo(12'hF00));
    probe("dbl_box0_not_x0", 0, 1, 1'b1, 12'h000);
    probe("dbl_box0_not_x2", 66, 10, 1'b1, 12'h000);
    probe_boxes("dbl");

    // Reset in the middle of a sweep
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    model_reset();
    probe("midrst_box0_origin", 0, 0, 1'b1, eo(12'hF00));
    probe_boxes("midrst");
    tick();
    probe_boxes("midrst_t1");

    // Long run: edge landings and bounces
    do_reset();
    for (int t = 1; t <= 151; t++) begin
      tick();
      if (t == 32) begin
        probe("t32_box1_at_x0", 5, 60, 1'b1, 12'h0F0);
        probe_boxes("t32");
      end
      if (t == 33) begin
        probe("t33_box1_bounced", 5, 60, 1'b1, 12'hFF0);
        probe("t33_box1_above", 5, 56, 1'b1, 12'h000);
        probe_boxes("t33");
      end
      if (t == 34) probe_boxes("t34");
      if (t == 149) begin
        probe("t149_box2_corner", 575, 197, 1'b1, eo(12'hFF0));
        probe("t149_box2_interior", 580, 200, 1'b1, 12'hFF0);
        probe("t149_left_of_box2", 574, 200, 1'b1, 12'h000);
        probe_boxes("t149");
      end
      if (t == 150) begin
        probe("t150_box2_interior", 580, 200, 1'b1, 12'h00F);
        probe("t150_left_of_box2", 575, 200, 1'b1, 12'h000);
        probe("t150_box2_right_col", 639, 200, 1'b1, eo(12'h00F));
        probe_boxes("t150");
      end
      if (t == 151) begin
        probe("t151_box2_moving_left", 573, 200, 1'b1, eo(12'h00F));
        probe_boxes("t151");
      end
    end

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bounce_sprites.md
Name: bounce_sprites

Overview:
Parametrised multi-box screensaver renderer and the successor to the single-box image generator. It holds NUM_BOXES independently bouncing boxes. Box state updates sequentially, one box per clock, on each frame tick. Each box reflects off the screen edges and advances its colour on every bounce. Pixel colour is composited with fixed index priority and registered. It sits between the video timer (position, visible, frame tick) and the RGB pins.

Parameters:
SCREEN_WIDTH, 640, visible pixels per line
SCREEN_HEIGHT, 480, visible lines
NUM_BOXES, 4, number of boxes; constraint (NUM_BOXES+1)*BOX_WIDTH <= SCREEN_WIDTH and (NUM_BOXES+1)*BOX_HEIGHT/2 <= SCREEN_HEIGHT
BOX_WIDTH, 64, box width in pixels
BOX_HEIGHT, 48, box height in pixels
VEL_W, 4, signed velocity width (two's complement)

Ports:
clk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
frame_tick  in  1  one-cycle pulse at vblank start
visible  in  1  current pixel is in the active area
position_x  in  $clog2(SCREEN_WIDTH)  pixel x, presented one cycle ahead of display
position_y  in  $clog2(SCREEN_HEIGHT)  pixel y, presented one cycle ahead of display
r  out  4  red
g  out  4  green
b  out  4  blue
busy  out  1  update sweep in progress
done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- X_LIMIT = SCREEN_WIDTH-BOX_WIDTH, Y_LIMIT = SCREEN_HEIGHT-BOX_HEIGHT.
- Position registers are one bit wider than the port width. Trajectory arithmetic is signed, with sign-extended velocity.
- Reset values for box i:
  - x = i*BOX_WIDTH, y = i*(BOX_HEIGHT/2)
  - vx = (i odd ? -1 : +1)*(1+(i mod 3)), vy = +1
  - color = (i mod 7)+1
- Other reset values: FSM = IDLE, idx = 0, busy = 0, done = 0, r = g = b = 0.
- FSM states:
  - IDLE: on frame_tick, go to UPDATE with idx = 0.
  - UPDATE: update box idx each cycle. busy = 1. After idx = NUM_BOXES-1, go to IDLE and pulse done for 1 cycle on entering IDLE.
- Sweep latency: NUM_BOXES cycles from frame_tick to done.
- frame_tick while busy is ignored. It is not queued.
- Per-axis update (x shown, y identical with Y_LIMIT):
  - t = x+vx.
  - t < 0: x = 0, vx = -vx, hit.
  - t > X_LIMIT: x = X_LIMIT, vx = -vx, hit.
  - Otherwise x = t. t == 0 and t == X_LIMIT are exact landings, not hits.
- Colour update: a hit on either axis (or both) advances color by exactly 1, sequence 1..7 with 7 wrapping to 1. Colour never reaches 0.
- Render:
  - in_box[i] = x_i <= px < x_i+BOX_WIDTH and y_i <= py < y_i+BOX_HEIGHT.
  - The lowest set index wins.
  - Component value = color bit ? 4'hF : 4'h0, with bit 0 = r, bit 1 = g, bit 2 = b.
  - No box, or visible = 0: output 0.
  - r/g/b are registered, giving 1-cycle latency from position/visible.
- Rendering during a sweep reads live registers. frame_tick must be placed in vblank so nothing tears.
- rst mid-sweep: all state returns to reset values on the next edge, busy = 0, and the sweep is abandoned.

Optional Feature:
Macro BOUNCE_SPRITES_OUTLINE_EN.
- Defined: pixels on a winning box's first/last column or first/last row output r = g = b = 4'hF. Interior pixels use the colour rule.
- Undefined: boxes render solid colour and there is no outline logic.

Test Plan:
- Reset then one frame_tick -> busy high 4 cycles, done pulse on the cycle after. Final positions: box0 (1,1), box1 (62,25), box2 (131,49), box3 (191,73). Colours unchanged at 1,2,3,4.
- 33 frame_ticks -> after tick 32, box1 x = 0 with vx = -2 and colour 2. After tick 33, x = 0, vx = +2, colour 3.
- 150 frame_ticks -> after tick 149, box2 x = 575. After tick 150, x = 576, vx = -3, colour 4.
- After 1 tick, visible = 1, pixel (63,30) -> next cycle r = F, g = 0, b = 0 (box0 beats box1). Pixel (70,30) with visible = 0 -> r = g = b = 0.
- frame_tick pulsed again 2 cycles into a sweep -> only one update applied; box0 x = 1.
- rst asserted at sweep cycle 2 -> next cycle busy = 0, box0 at (0,0), box1 vx = -2, all colours at reset values.
